// File: rtl/fp8_mul_arbiter.sv
// Round-robin arbiter feeding one shared FP8 (E4M3) multiplier through a two-stage
// operand/result pipeline; products return with the owning requester index.
module fp8_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_p,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          issued_cnt
);

  localparam int unsigned IdxW = ID_W + 1;

  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;

  logic              res_load;
  logic              op_free;
  logic              found;
  logic              accept;
  logic [ID_W-1:0]   winner;
  logic [IdxW-1:0]   rr_idx;
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*DATA_W +: DATA_W];
      b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end
  end

  assign res_load = op_valid_q && (!rsp_valid_q || rsp_ready);
  assign op_free  = !op_valid_q || res_load;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    winner = last_grant_q;
    found  = 1'b0;
    rr_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_idx = {1'b0, last_grant_q} + IdxW'(k);
      if (rr_idx >= IdxW'(NUM_REQ)) begin
        rr_idx = rr_idx - IdxW'(NUM_REQ);
      end
      if (!found && req_valid[rr_idx[ID_W-1:0]]) begin
        winner = rr_idx[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

  // Reset gates the grant so nothing is offered while the pipeline is held clear.
  assign accept = found && op_free && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    op_valid_d   = op_valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    issued_cnt_d = issued_cnt_q;

    if (accept) begin
      op_valid_d   = 1'b1;
      op_a_d       = a_arr[winner];
      op_b_d       = b_arr[winner];
      op_id_d      = winner;
      last_grant_d = winner;
      issued_cnt_d = issued_cnt_q + CNT_W'(1);
    end else if (res_load) begin
      op_valid_d = 1'b0;
    end

    // A load on the same edge as a drain replaces the old response without a bubble.
    if (res_load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mul_p;
      rsp_id_d    = op_id_q;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      issued_cnt_q <= '0;
    end else begin
      op_valid_q   <= op_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign mul_a      = op_a_q;
  assign mul_b      = op_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Directed bench for fp8_mul_arbiter: a second instance with a 4-bit counter shares
// the stimulus to exercise counter wrap.
module tb_fp8_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_ready;

  logic [3:0]  req_ready;
  logic [7:0]  mul_a, mul_b, mul_p;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] issued_cnt;

  logic [3:0]  w_req_ready;
  logic [7:0]  w_mul_a, w_mul_b, w_mul_p;
  logic        w_rsp_valid;
  logic [7:0]  w_rsp_data;
  logic [1:0]  w_rsp_id;
  logic [3:0]  w_issued_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt [4];
  int rsp_cnt [4];

  always #5 clk = ~clk;

  // Truncating E4M3 multiply; exact for the power-of-two operands used here.
  function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
    logic       s;
    int         e;
    logic [7:0] p;
    logic [2:0] m;
    s = a[7] ^ b[7];
    if (a[6:3] == 4'd0 || b[6:3] == 4'd0) return {s, 7'd0};
    p = {4'd0, 1'b1, a[2:0]} * {4'd0, 1'b1, b[2:0]};
    e = int'(a[6:3]) + int'(b[6:3]) - 7;
    if (p[7]) begin
      m = p[6:4];
      e = e + 1;
    end else begin
      m = p[5:3];
    end
    if (e > 15 || (e == 15 && m == 3'd7)) return {s, 7'h7e};
    if (e <= 0) return {s, 7'd0};
    return {s, 4'(e), m};
  endfunction

  always_comb mul_p   = fp8_mul(mul_a, mul_b);
  always_comb w_mul_p = fp8_mul(w_mul_a, w_mul_b);

  fp8_mul_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .issued_cnt (issued_cnt)
  );

  fp8_mul_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (w_req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (w_mul_a),
    .mul_b      (w_mul_b),
    .mul_p      (w_mul_p),
    .rsp_valid  (w_rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (w_rsp_data),
    .rsp_id     (w_rsp_id),
    .issued_cnt (w_issued_cnt)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) acc_cnt[i]++;
      if (rsp_valid && rsp_ready) rsp_cnt[rsp_id]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_stream_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'h38;
      req_b[i*8 +: 8] = 8'(8'h38 + 8 * i);
    end
  endtask

  int bp_rdy [12] = '{1, 2, 0, 0, 0, 0, 0, 4, 8, 0, 0, 0};
  int bp_id  [12] = '{-1, -1, 0, 0, 0, 0, 0, 0, 1, 2, 3, -1};

  initial begin
    // Reset state, with requests pending to show req_ready is held low.
    rst_n = 1'b0;
    req_valid = 4'hf;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    #3;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_cnt", 32'(issued_cnt), 32'h0);
    check("rst_mul_a", 32'(mul_a), 32'h0);
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    #1;

    // Single request from requester 2: 1.0 * 2.0.
    req_a[16 +: 8] = 8'h38;
    req_b[16 +: 8] = 8'h40;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1;
    check("single_rsp_early", 32'(rsp_valid), 32'h0);
    check("single_mul_a", 32'(mul_a), 32'h38);
    check("single_mul_b", 32'(mul_b), 32'h40);
    tick();
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_data", 32'(rsp_data), 32'h40);
    check("single_rsp_id", 32'(rsp_id), 32'h2);
    check("single_cnt", 32'(issued_cnt), 32'h1);

    // Round-robin with all four requesters continuously valid.
    do_reset();
    set_stream_ops();
    req_valid = 4'hf;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) check("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rr_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
        check("rr_rsp_data", 32'(rsp_data), 32'(8'h38 + 8 * ((c - 2) % 4)));
      end
      tick();
    end
    check("rr_drained", 32'(rsp_valid), 32'h0);
    check("rr_cnt", 32'(issued_cnt), 32'd8);

    // Backpressure: rsp_ready low for five cycles mid-stream.
    for (int i = 0; i < 4; i++) begin
      acc_cnt[i] = 0;
      rsp_cnt[i] = 0;
    end
    req_valid = 4'hf;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) rsp_ready = 1'b0;
      if (c == 7) rsp_ready = 1'b1;
      if (c == 9) req_valid = '0;
      #1;
      check("bp_ready", 32'(req_ready), 32'(bp_rdy[c]));
      if (bp_id[c] < 0) begin
        check("bp_rsp_idle", 32'(rsp_valid), 32'h0);
      end else begin
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp_rsp_id", 32'(rsp_id), 32'(bp_id[c]));
        check("bp_rsp_data", 32'(rsp_data), 32'(8'h38 + 8 * bp_id[c]));
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("bp_acc_cnt", 32'(acc_cnt[i]), 32'd1);
      check("bp_rsp_cnt", 32'(rsp_cnt[i]), 32'd1);
    end
    check("bp_cnt", 32'(issued_cnt), 32'd12);

    // Sign path: -1.0 * 1.0 from requester 1.
    req_a[8 +: 8] = 8'hb8;
    req_b[8 +: 8] = 8'h38;
    req_valid = 4'b0010;
    #1;
    check("sign_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #1;
    check("sign_mul_a", 32'(mul_a), 32'hb8);
    tick();
    check("sign_rsp_valid", 32'(rsp_valid), 32'h1);
    check("sign_rsp_data", 32'(rsp_data), 32'hb8);
    check("sign_rsp_id", 32'(rsp_id), 32'h1);
    check("sign_cnt", 32'(issued_cnt), 32'd13);

    // Asynchronous reset with both stages full; last grant before reset is requester 2.
    set_stream_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    tick();
    tick();
    check("mid_full", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_mul_a", 32'(mul_a), 32'h0);
    check("mid_mul_b", 32'(mul_b), 32'h0);
    check("mid_cnt", 32'(issued_cnt), 32'h0);
    check("mid_ready", 32'(req_ready), 32'h0);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("mid_first_grant", 32'(req_ready), 32'h1);

    // Counter wrap: 17 accepts.
    for (int k = 0; k < 17; k++) tick();
    req_valid = '0;
    #1;
    check("wrap_cnt16", 32'(issued_cnt), 32'd17);
    check("wrap_cnt4", 32'(w_issued_cnt), 32'd1);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
